// File: rtl/mul_issue_q.sv
// Operand issue FIFO in front of a combinational fp32 multiplier, plus a
// registered result stage with valid/ready handshake and result-class flags.
module mul_issue_q #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    localparam int DW    = SIGN_W + EXPO_W + MANT_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    input  logic [1:0]       in_rnd,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic [DW-1:0]    mul_a,
    output logic [DW-1:0]    mul_b,
    output logic [1:0]       mul_rnd,
    input  logic [DW-1:0]    mul_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags,
    output logic [CW-1:0]    count
);

    logic [DW-1:0]    r_mem_a   [DEPTH];
    logic [DW-1:0]    r_mem_b   [DEPTH];
    logic [1:0]       r_mem_rnd [DEPTH];
    logic [TAG_W-1:0] r_mem_tag [DEPTH];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_out_valid;
    logic [DW-1:0]    r_out_res;
    logic [TAG_W-1:0] r_out_tag;
    logic [3:0]       r_out_flags;

    logic             w_full;
    logic             w_head_vld;
    logic             w_push;
    logic             w_pop;
    logic [EXPO_W-1:0] w_expo;
    logic [MANT_W-1:0] w_mant;
    logic             w_expo_ones;
    logic             w_expo_zero;
    logic             w_mant_zero;
    logic [3:0]       w_flags;

    // Readiness comes from the registered count only; a pop in the same cycle
    // does not free a slot for the incoming operand.
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_head_vld = (r_count != '0);
    assign in_ready   = ~w_full;

    assign w_push = in_valid & ~w_full & ~flush;
    assign w_pop  = w_head_vld & (~r_out_valid | out_ready) & ~flush;

    assign mul_a   = w_head_vld ? r_mem_a[r_rd_ptr]   : '0;
    assign mul_b   = w_head_vld ? r_mem_b[r_rd_ptr]   : '0;
    assign mul_rnd = w_head_vld ? r_mem_rnd[r_rd_ptr] : '0;

    assign w_expo      = mul_res[MANT_W +: EXPO_W];
    assign w_mant      = mul_res[MANT_W-1:0];
    assign w_expo_ones = &w_expo;
    assign w_expo_zero = ~|w_expo;
    assign w_mant_zero = ~|w_mant;
    assign w_flags     = {w_expo_ones & ~w_mant_zero, w_expo_ones & w_mant_zero,
                          w_expo_zero & w_mant_zero,  w_expo_zero & ~w_mant_zero};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]   <= in_a;
            r_mem_b[r_wr_ptr]   <= in_b;
            r_mem_rnd[r_wr_ptr] <= in_rnd;
            r_mem_tag[r_wr_ptr] <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Result data is only overwritten by a new capture; a drain or flush
    // just clears the valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_res   <= '0;
            r_out_tag   <= '0;
            r_out_flags <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_res   <= mul_res;
            r_out_tag   <= r_mem_tag[r_rd_ptr];
            r_out_flags <= w_flags;
        end else if (r_out_valid & out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
    assign out_tag   = r_out_tag;
    assign out_flags = r_out_flags;
    assign count     = r_count;

endmodule

// File: tb/tb_mul_issue_q.sv
// Bench for mul_issue_q: a stand-in multiplier drives mul_res, a scoreboard
// tracks accepted operations and checks every result handed to the consumer.
module tb_mul_issue_q;

    localparam int DW = 32;

    logic          clk, rst;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_a, in_b;
    logic [1:0]    in_rnd;
    logic [3:0]    in_tag;
    logic          flush;
    logic [DW-1:0] mul_a, mul_b, mul_res;
    logic [1:0]    mul_rnd;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_res;
    logic [3:0]    out_tag, out_flags;
    logic [2:0]    count;

    mul_issue_q dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_rnd(in_rnd), .in_tag(in_tag),
        .flush(flush),
        .mul_a(mul_a), .mul_b(mul_b), .mul_rnd(mul_rnd), .mul_res(mul_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag), .out_flags(out_flags),
        .count(count)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [3:0]  flags;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Known products for the directed vectors; anything else gets a cheap
    // deterministic scramble so ordering errors still show up.
    function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] rnd);
        if (a == 32'h40400000 && b == 32'h40000000) return 32'h40C00000;
        if (a == 32'h7F800000 && b == 32'h00000000) return 32'h7FC00000;
        if (a == 32'h7F000000 && b == 32'h40000000) return (rnd == 2'b00) ? 32'h7F7FFFFF : 32'h7F800000;
        if (a == 32'h00800000 && b == 32'h3F000000) return 32'h00400000;
        if (a == 32'h00000000 && b == 32'h3F800000) return 32'h00000000;
        return a ^ {b[15:0], b[31:16]} ^ {30'b0, rnd};
    endfunction

    function automatic logic [3:0] fclass(input logic [31:0] r);
        logic [7:0]  e;
        logic [22:0] m;
        e = r[30:23];
        m = r[22:0];
        return {(e == 8'hFF) && (m != 0), (e == 8'hFF) && (m == 0),
                (e == 8'h00) && (m == 0), (e == 8'h00) && (m != 0)};
    endfunction

    assign mul_res = fmul_model(mul_a, mul_b, mul_rnd);

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change #1 after posedge, so the negedge sees what the next edge will use.
    always @(negedge clk) begin
        if (!rst && !flush) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_res", out_res, e.res);
                    chk("out_tag", out_tag, e.tag);
                    chk("out_flags", out_flags, e.flags);
                end
            end
            if (in_valid && in_ready) begin
                exp_t n;
                n.res   = fmul_model(in_a, in_b, in_rnd);
                n.tag   = in_tag;
                n.flags = fclass(n.res);
                sb.push_back(n);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rnd,
                         input logic [3:0] tag);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_rnd   = rnd;
        in_tag   = tag;
    endtask

    task automatic single_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rnd,
                             input logic [3:0] tag, input logic [31:0] eres, input logic [3:0] eflg);
        out_ready = 1'b1;
        drive(a, b, rnd, tag);
        tick();
        in_valid = 1'b0;
        chk("so_cnt1", count, 1);
        chk("so_mul_a", mul_a, a);
        chk("so_ov0", out_valid, 0);
        tick();
        chk("so_ov1", out_valid, 1);
        chk("so_res", out_res, eres);
        chk("so_tag", out_tag, tag);
        chk("so_flags", out_flags, eflg);
        chk("so_cnt0", count, 0);
        tick();
        chk("so_drained", out_valid, 0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((count != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", (count == 0 && !out_valid), 1);
        chk("sb_left", sb.size(), 0);
    endtask

    initial begin
        int acc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_rnd = '0; in_tag = '0;
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_rnd", mul_rnd, 0);
        chk("rst_res", {out_res, out_tag, out_flags}, 0);
        rst = 1'b0;
        tick();

        single_op(32'h40400000, 32'h40000000, 2'b11, 4'd5, 32'h40C00000, 4'b0000);
        single_op(32'h7F800000, 32'h00000000, 2'b11, 4'd1, 32'h7FC00000, 4'b1000);
        single_op(32'h7F000000, 32'h40000000, 2'b00, 4'd2, 32'h7F7FFFFF, 4'b0000);
        single_op(32'h7F000000, 32'h40000000, 2'b11, 4'd3, 32'h7F800000, 4'b0100);
        single_op(32'h00800000, 32'h3F000000, 2'b11, 4'd4, 32'h00400000, 4'b0001);
        single_op(32'h00000000, 32'h3F800000, 2'b01, 4'd6, 32'h00000000, 4'b0010);

        // Backpressure: six offers, five fit (four queued plus the output register).
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive($urandom, $urandom, 2'($urandom), 4'(i));
            acc += int'(in_ready);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, 5);
        chk("bp_count", count, 4);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_ov", out_valid, 1);
        chk("bp_hold_tag", out_tag, 0);

        // Full with a pop this cycle: no credit for the freed slot.
        out_ready = 1'b1;
        drive(32'h12345678, 32'h9ABCDEF0, 2'b10, 4'd9);
        chk("full_pop_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        chk("full_pop_count", count, 3);
        chk("full_pop_ready1", in_ready, 1);
        drain(20);

        // Flush with a queue and a held result; the flush-cycle offer is dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive($urandom, $urandom, 2'($urandom), 4'(i + 8));
            tick();
        end
        chk("fl_pre_count", count, 3);
        chk("fl_pre_ov", out_valid, 1);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(32'h11111111, 32'h22222222, 2'b00, 4'd7);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("fl_count", count, 0);
        chk("fl_ov", out_valid, 0);
        tick();
        chk("fl_no_stale", {count, out_valid}, 0);
        single_op(32'h40400000, 32'h40000000, 2'b11, 4'hA, 32'h40C00000, 4'b0000);

        // Asynchronous reset between edges.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, 2'($urandom), 4'(i + 1));
            tick();
        end
        in_valid = 1'b0;
        chk("ar_pre_count", count, 2);
        #2 rst = 1'b1;
        #1;
        chk("ar_ov", out_valid, 0);
        chk("ar_count", count, 0);
        chk("ar_mul_a", mul_a, 0);
        sb.delete();
        tick();
        #2 rst = 1'b0;
        tick();
        single_op(32'h7F800000, 32'h00000000, 2'b01, 4'hC, 32'h7FC00000, 4'b1000);

        // Random stream with random consumer stalls.
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = $urandom;
            in_b      = $urandom;
            in_rnd    = 2'($urandom);
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (count > 3'd4) chk("rand_count_max", count, 4);
        end
        drain(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
